// File: rtl/ir_ctrl_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-states and the control word.
// Build option: SAP_EARLY_END_EN (early return to T1, used in ir_ctrl).
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  typedef struct packed {
    logic pc_inc;
    logic pc_oe;
    logic mar_ld;
    logic mem_oe;
    logic ir_oe;
    logic a_ld;
    logic a_oe;
    logic b_ld;
    logic alu_oe;
    logic alu_sub;
    logic out_ld;
  } ctrl_t;

endpackage

// File: rtl/ir_ctrl_if.sv
// Signal bundle between the SAP-1 datapath and the instruction controller.
// run is a level advance enable, not a handshake: while it is high the
// sequencer steps once per clock; while low, state and control word hold.
interface ir_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
);
  logic                 run;
  logic [WIDTH-1:0]     bus;
  logic [OPW-1:0]       opcode;
  logic [WIDTH-OPW-1:0] operand;
  logic [5:0]           tstate;
  logic                 pc_inc;
  logic                 pc_oe;
  logic                 mar_ld;
  logic                 mem_oe;
  logic                 ir_oe;
  logic                 a_ld;
  logic                 a_oe;
  logic                 b_ld;
  logic                 alu_oe;
  logic                 alu_sub;
  logic                 out_ld;
  logic                 halt;

  // Datapath side: supplies run and the bus, consumes the control word.
  modport master (
    output run, bus,
    input  opcode, operand, tstate, pc_inc, pc_oe, mar_ld, mem_oe, ir_oe,
           a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halt
  );

  // Controller side.
  modport slave (
    input  run, bus,
    output opcode, operand, tstate, pc_inc, pc_oe, mar_ld, mem_oe, ir_oe,
           a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halt
  );
endinterface

// File: rtl/ir_ctrl_tstate_ring.sv
// Six-state one-hot ring counter T1..T6; restart wins over adv.
module tstate_ring
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       restart,
  output logic [5:0] tstate
);

  logic [5:0] ring_q;
  logic [5:0] ring_d;

  // Next state: jump to T1, rotate one place, or hold.
  always_comb begin
    ring_d = ring_q;
    if (restart) begin
      ring_d = T1;
    end else if (adv) begin
      ring_d = {ring_q[4:0], ring_q[5]};
    end
  end

  // State register, T1 on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q <= T1;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign tstate = ring_q;

endmodule

// File: rtl/ir_ctrl.sv
// SAP-1 instruction register, halt flop and control-word decode.
// Build option: SAP_EARLY_END_EN returns to T1 right after an opcode's last
// active T-state (LDA 5 cycles, OUT/NOP 4); otherwise every non-HLT
// instruction takes 6 cycles.
module ir_ctrl
  import sap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic       clk,
  input  logic       rst,
  ir_ctrl_if.slave   io
);

  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] ir_d;
  logic             halt_q;
  logic             halt_d;
  logic [5:0]       tstate;
  logic             adv;
  logic             restart;
  logic             hlt_t4;
  logic [3:0]       op;
  ctrl_t            ctrl;

  assign op     = 4'(ir_q[WIDTH-1 -: OPW]);
  assign hlt_t4 = (tstate == T4) && (op == OP_HLT);

  // Sequencer enable, IR capture at the end of T3 and sticky halt set.
  always_comb begin
    adv    = io.run && !halt_q && !hlt_t4;
    ir_d   = ir_q;
    halt_d = halt_q;
    if (adv && (tstate == T3)) begin
      ir_d = io.bus;
    end
    if (io.run && hlt_t4) begin
      halt_d = 1'b1;
    end
  end

`ifdef SAP_EARLY_END_EN
  logic is_last;

  // Last active T-state of the current opcode triggers an early restart.
  always_comb begin
    is_last = 1'b0;
    case (op)
      OP_LDA:         is_last = (tstate == T5);
      OP_ADD, OP_SUB: is_last = (tstate == T6);
      OP_HLT:         is_last = 1'b0;
      default:        is_last = (tstate == T4);
    endcase
    restart = adv && is_last;
  end
`else
  assign restart = 1'b0;
`endif

  // IR and halt registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      halt_q <= halt_d;
    end
  end

  tstate_ring u_ring (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .restart (restart),
    .tstate  (tstate)
  );

  // Control word decode; all zero in reset and once halted.
  always_comb begin
    ctrl = '0;
    if (rst && !halt_q) begin
      case (tstate)
        T1: begin
          ctrl.pc_oe  = 1'b1;
          ctrl.mar_ld = 1'b1;
        end
        T2: ctrl.pc_inc = 1'b1;
        T3: ctrl.mem_oe = 1'b1;
        T4: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.ir_oe  = 1'b1;
              ctrl.mar_ld = 1'b1;
            end
            OP_OUT: begin
              ctrl.a_oe   = 1'b1;
              ctrl.out_ld = 1'b1;
            end
            default: ctrl = '0;
          endcase
        end
        T5: begin
          case (op)
            OP_LDA: begin
              ctrl.mem_oe = 1'b1;
              ctrl.a_ld   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.mem_oe  = 1'b1;
              ctrl.b_ld    = 1'b1;
              ctrl.alu_sub = (op == OP_SUB);
            end
            default: ctrl = '0;
          endcase
        end
        T6: begin
          if ((op == OP_ADD) || (op == OP_SUB)) begin
            ctrl.alu_oe  = 1'b1;
            ctrl.a_ld    = 1'b1;
            ctrl.alu_sub = (op == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign io.opcode  = ir_q[WIDTH-1 -: OPW];
  assign io.operand = ir_q[WIDTH-OPW-1:0];
  assign io.tstate  = tstate;
  assign io.halt    = halt_q;
  assign io.pc_inc  = ctrl.pc_inc;
  assign io.pc_oe   = ctrl.pc_oe;
  assign io.mar_ld  = ctrl.mar_ld;
  assign io.mem_oe  = ctrl.mem_oe;
  assign io.ir_oe   = ctrl.ir_oe;
  assign io.a_ld    = ctrl.a_ld;
  assign io.a_oe    = ctrl.a_oe;
  assign io.b_ld    = ctrl.b_ld;
  assign io.alu_oe  = ctrl.alu_oe;
  assign io.alu_sub = ctrl.alu_sub;
  assign io.out_ld  = ctrl.out_ld;

endmodule

// File: tb/tb_ir_ctrl.sv
// Directed bench for ir_ctrl: fetch/execute control words, stall, mid-reset,
// halt and instruction length with or without SAP_EARLY_END_EN.
module tb_ir_ctrl;

  // Bit positions of the control word as packed below.
  localparam int C_PC_INC  = 10;
  localparam int C_PC_OE   = 9;
  localparam int C_MAR_LD  = 8;
  localparam int C_MEM_OE  = 7;
  localparam int C_IR_OE   = 6;
  localparam int C_A_LD    = 5;
  localparam int C_A_OE    = 4;
  localparam int C_B_LD    = 3;
  localparam int C_ALU_OE  = 2;
  localparam int C_ALU_SUB = 1;
  localparam int C_OUT_LD  = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ir_ctrl_if #(.WIDTH(8), .OPW(4)) io ();

  ir_ctrl #(.WIDTH(8), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int checks   = 0;
  int failures = 0;

  logic [10:0] ctrl_w;
  logic [4:0]  drivers;
  assign ctrl_w  = {io.pc_inc, io.pc_oe, io.mar_ld, io.mem_oe, io.ir_oe,
                    io.a_ld, io.a_oe, io.b_ld, io.alu_oe, io.alu_sub, io.out_ld};
  assign drivers = {io.pc_oe, io.mem_oe, io.ir_oe, io.a_oe, io.alu_oe};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected control word for T-state k (1..6) of opcode op.
  function automatic logic [10:0] exp_ctrl(input int k, input logic [3:0] op);
    logic [10:0] c;
    c = '0;
    case (k)
      1: begin c[C_PC_OE] = 1'b1; c[C_MAR_LD] = 1'b1; end
      2: c[C_PC_INC] = 1'b1;
      3: c[C_MEM_OE] = 1'b1;
      4: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
          c[C_IR_OE] = 1'b1; c[C_MAR_LD] = 1'b1;
        end else if (op == 4'hE) begin
          c[C_A_OE] = 1'b1; c[C_OUT_LD] = 1'b1;
        end
      end
      5: begin
        if (op == 4'h0) begin
          c[C_MEM_OE] = 1'b1; c[C_A_LD] = 1'b1;
        end else if (op == 4'h1 || op == 4'h2) begin
          c[C_MEM_OE] = 1'b1; c[C_B_LD] = 1'b1; c[C_ALU_SUB] = (op == 4'h2);
        end
      end
      6: begin
        if (op == 4'h1 || op == 4'h2) begin
          c[C_ALU_OE] = 1'b1; c[C_A_LD] = 1'b1; c[C_ALU_SUB] = (op == 4'h2);
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Expected instruction length in cycles (non-HLT opcodes).
  function automatic int exp_len(input logic [3:0] op);
`ifdef SAP_EARLY_END_EN
    if (op == 4'h1 || op == 4'h2) return 6;
    if (op == 4'h0) return 5;
    return 4;
`else
    return (op == 4'hF) ? 4 : 6;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    io.run = 1'b0;
    io.bus = 8'h00;
    step();
    step();
    check("rst_tstate", {26'd0, io.tstate}, 32'h01);
    check("rst_ctrl", {21'd0, ctrl_w}, 32'h0);
    check("rst_halt", {31'd0, io.halt}, 32'h0);
    check("rst_opcode", {28'd0, io.opcode}, 32'h0);
    rst    = 1'b1;
    io.run = 1'b1;
    #1;
    check("rel_ctrl_t1", {21'd0, ctrl_w}, 32'h300);
  endtask

  // Run one full non-HLT instruction starting at T1; ends back at T1.
  task automatic run_instr(input logic [7:0] b);
    logic [3:0] op;
    logic [3:0] arg;
    int n;
    op  = b[7:4];
    arg = b[3:0];
    n   = exp_len(op);
    io.bus = b;
    #1;
    for (int k = 1; k <= n; k++) begin
      check($sformatf("tstate op%h T%0d", op, k), {26'd0, io.tstate}, 32'(1 << (k - 1)));
      check($sformatf("ctrl op%h T%0d", op, k), {21'd0, ctrl_w}, {21'd0, exp_ctrl(k, op)});
      check($sformatf("drv_excl op%h T%0d", op, k), 32'(($countones(drivers) <= 1) ? 1 : 0), 32'd1);
      if (k >= 4) begin
        check($sformatf("opcode op%h T%0d", op, k), {28'd0, io.opcode}, {28'd0, op});
        check($sformatf("operand op%h T%0d", op, k), {28'd0, io.operand}, {28'd0, arg});
      end
      step();
      #1;
    end
    check($sformatf("len op%h back_to_t1", op), {26'd0, io.tstate}, 32'h01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // ADD, SUB, LDA, OUT, NOP back to back
    run_instr(8'h1D);
    run_instr(8'h2A);
    run_instr(8'h05);
    run_instr(8'hE0);
    run_instr(8'h70);

    // run low for three edges while in T2
    step();
    check("stall_t2_enter", {26'd0, io.tstate}, 32'h02);
    io.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_t2_hold%0d", i), {26'd0, io.tstate}, 32'h02);
      check($sformatf("stall_pc_inc%0d", i), {31'd0, io.pc_inc}, 32'h1);
    end
    io.run = 1'b1;
    step();
    check("stall_resume_t3", {26'd0, io.tstate}, 32'h04);
    check("stall_resume_ctrl", {21'd0, ctrl_w}, 32'h080);

    // reset pulse during T5 of LDA
    do_reset();
    io.bus = 8'h05;
    for (int i = 0; i < 4; i++) step();
    check("lda_t5_state", {26'd0, io.tstate}, 32'h10);
    check("lda_t5_ctrl", {21'd0, ctrl_w}, 32'h0A0);
    rst = 1'b0;
    #1;
    check("midrst_tstate", {26'd0, io.tstate}, 32'h01);
    check("midrst_opcode", {28'd0, io.opcode}, 32'h0);
    check("midrst_operand", {28'd0, io.operand}, 32'h0);
    check("midrst_ctrl", {21'd0, ctrl_w}, 32'h0);
    step();
    check("midrst_ctrl_hold", {21'd0, ctrl_w}, 32'h0);
    rst = 1'b1;
    #1;
    check("postrst_t1", {26'd0, io.tstate}, 32'h01);
    check("postrst_ctrl", {21'd0, ctrl_w}, 32'h300);
    step();
    check("postrst_t2", {26'd0, io.tstate}, 32'h02);
    check("postrst_t2_ctrl", {21'd0, ctrl_w}, 32'h400);

    // HLT: sticky, frozen at T4
    do_reset();
    io.bus = 8'hF0;
    for (int i = 0; i < 3; i++) step();
    check("hlt_t4_state", {26'd0, io.tstate}, 32'h08);
    check("hlt_t4_ctrl", {21'd0, ctrl_w}, 32'h0);
    check("hlt_t4_halt_pre", {31'd0, io.halt}, 32'h0);
    check("hlt_opcode", {28'd0, io.opcode}, 32'hF);
    for (int i = 0; i < 21; i++) begin
      step();
      check($sformatf("hlt_halt%0d", i), {31'd0, io.halt}, 32'h1);
      check($sformatf("hlt_state%0d", i), {26'd0, io.tstate}, 32'h08);
      check($sformatf("hlt_ctrl%0d", i), {21'd0, ctrl_w}, 32'h0);
    end
    rst = 1'b0;
    #1;
    check("hlt_clear_halt", {31'd0, io.halt}, 32'h0);
    check("hlt_clear_state", {26'd0, io.tstate}, 32'h01);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
